// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD path: FSM states, HD44780 command bytes and
// the long-execution classifier.
package lcd_pkg;

  typedef enum logic [2:0] {
    POR_WAIT = 3'd0,
    IDLE     = 3'd1,
    SETUP    = 3'd2,
    PULSE    = 3'd3,
    HOLD     = 3'd4,
    EXEC     = 3'd5
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON = 8'h0E;
  localparam logic [7:0] CMD_FUNC_8B2L  = 8'h38;
  localparam logic [7:0] CMD_LINE2      = 8'hC0;
  localparam logic [7:0] CMD_SHIFT_R    = 8'h14;

  // Clear (0x01) and return-home (0x02/0x03, bit 0 is don't-care) need the
  // long execution wait; every other instruction and all character data use
  // the short one.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == 7'b0000001));
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_phy_if.sv
// Write-request handshake from the sequencer plus the display pins it drives.
interface lcd_bus_phy_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       req_rs;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic       busy;

  modport master (
    output req_valid, req_data, req_rs,
    input  req_ready, lcd_en, lcd_rs, lcd_rw, lcd_data, busy
  );

  modport slave (
    input  req_valid, req_data, req_rs,
    output req_ready, lcd_en, lcd_rs, lcd_rw, lcd_data, busy
  );
endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every bus phase. Load (length - 1) on phase
// entry; done is high while the count sits at zero.
module lcd_delay_timer #(
  parameter int unsigned     CW      = 8,
  parameter logic [CW-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_d, cnt_q;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // Reset value is the first phase length so the power-on wait starts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_phy.sv
// HD44780 bus PHY: takes one byte write per handshake and sequences
// setup / enable pulse / hold / blind execution wait on the display pins.
// Also owns the power-on wait after reset.
module lcd_bus_phy
  import lcd_pkg::*;
#(
  parameter int unsigned T_POR       = 2_000_000,
  parameter int unsigned T_SETUP     = 3,
  parameter int unsigned T_EN        = 25,
  parameter int unsigned T_HOLD      = 3,
  parameter int unsigned T_EXEC      = 2_000,
  parameter int unsigned T_EXEC_LONG = 82_000
) (
  input  logic          clk,
  input  logic          rst_n,
  lcd_bus_phy_if.slave  bus
);

  localparam int unsigned T_MAX = max_of(max_of(max_of(T_POR, T_SETUP), max_of(T_EN, T_HOLD)),
                                         max_of(T_EXEC, T_EXEC_LONG));
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] LD_POR   = CW'(T_POR - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);

  lcd_state_e    state_d, state_q;
  logic          en_d, en_q;
  logic          rs_d, rs_q;
  logic [7:0]    data_d, data_q;
  logic          ready_d, ready_q;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  lcd_delay_timer #(.CW(CW), .RST_VAL(LD_POR)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state and next-pin values. Pins change only on phase transitions;
  // RS/data only on an accept, so they persist through EXEC and IDLE.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    rs_d     = rs_q;
    data_d   = data_q;
    ready_d  = ready_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      POR_WAIT: if (tmr_done) begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      IDLE: if (bus.req_valid) begin
        state_d  = SETUP;
        ready_d  = 1'b0;
        rs_d     = bus.req_rs;
        data_d   = bus.req_data;
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
      end
      SETUP: if (tmr_done) begin
        state_d  = PULSE;
        en_d     = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = LD_EN;
      end
      PULSE: if (tmr_done) begin
        state_d  = HOLD;
        en_d     = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = LD_HOLD;
      end
      // The latched byte is still on the bus, so classify from the pins.
      HOLD: if (tmr_done) begin
        state_d  = EXEC;
        tmr_load = 1'b1;
        tmr_val  = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
      end
      EXEC: if (tmr_done) begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = POR_WAIT;
        ready_d = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  // FSM and pin registers; async reset drops EN immediately and restarts POR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= POR_WAIT;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = ~ready_q;
  assign bus.lcd_en    = en_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_data  = data_q;
  assign bus.lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_bus_phy.sv
// Directed bench for lcd_bus_phy with shortened timing parameters.
module tb_lcd_bus_phy;
  import lcd_pkg::*;

  localparam int P_POR  = 10;
  localparam int P_SET  = 2;
  localparam int P_EN   = 4;
  localparam int P_HOLD = 2;
  localparam int P_EXEC = 8;
  localparam int P_LONG = 20;
  localparam int OFF_SHORT = P_SET + P_EN + P_HOLD + P_EXEC;  // 16
  localparam int OFF_LONG  = P_SET + P_EN + P_HOLD + P_LONG;  // 28

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  lcd_bus_phy_if bus();

  lcd_bus_phy #(
    .T_POR(P_POR), .T_SETUP(P_SET), .T_EN(P_EN), .T_HOLD(P_HOLD),
    .T_EXEC(P_EXEC), .T_EXEC_LONG(P_LONG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         en_rises = 0;
  logic       en_prev = 1'b0;
  logic [7:0] last_data = 8'h00;
  time        acc_t[$];

  // Count EN rising transitions as seen at the sampling edge.
  always @(negedge clk) begin
    if (bus.lcd_en && !en_prev) en_rises <= en_rises + 1;
    en_prev <= bus.lcd_en;
  end

  // One complete write: wait for ready, accept, then check every cycle up to
  // ready returning. Offset k is the state after accept edge E+k.
  task automatic check_write(input logic [7:0] d, input logic rs, input int rdy_off,
                             input logic keep);
    int t;
    logic exp_en, exp_rdy;
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    bus.req_rs    = rs;
    t = 0;
    while (!bus.req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!bus.req_ready) begin
      n_err++;
      $display("FAIL wr_%02h_ready_wait: ready=%0b want 1 within 300 cycles", d, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_t.push_back($time);
    for (int k = 0; k <= rdy_off; k++) begin
      @(negedge clk);
      // Garbage on the request side while busy must not reach the pins.
      if (k == 1) begin
        bus.req_data = ~d;
        bus.req_rs   = ~rs;
      end
      exp_en  = (k >= P_SET) && (k < P_SET + P_EN);
      exp_rdy = (k == rdy_off);
      n_cmp += 4;
      if (bus.lcd_data !== d) begin
        n_err++; $display("FAIL wr_%02h_data k=%0d: got %02h want %02h", d, k, bus.lcd_data, d);
      end
      if (bus.lcd_rs !== rs) begin
        n_err++; $display("FAIL wr_%02h_rs k=%0d: got %0b want %0b", d, k, bus.lcd_rs, rs);
      end
      if (bus.lcd_en !== exp_en) begin
        n_err++; $display("FAIL wr_%02h_en k=%0d: got %0b want %0b", d, k, bus.lcd_en, exp_en);
      end
      if (bus.req_ready !== exp_rdy || bus.busy !== ~exp_rdy) begin
        n_err++;
        $display("FAIL wr_%02h_ready k=%0d: ready=%0b busy=%0b want ready=%0b", d, k,
                 bus.req_ready, bus.busy, exp_rdy);
      end
    end
    if (!keep) bus.req_valid = 1'b0;
    last_data = d;
  endtask

  // Reset values, then the POR wait with a request already pending.
  task automatic test_reset();
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h41;
    bus.req_rs    = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.lcd_en !== 1'b0 || bus.lcd_rs !== 1'b0 || bus.lcd_data !== 8'h00 ||
        bus.lcd_rw !== 1'b0 || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_vals: en=%0b rs=%0b data=%02h rw=%0b ready=%0b busy=%0b want 0 0 00 0 0 1",
               bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.lcd_rw, bus.req_ready, bus.busy);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= P_POR; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== (k == P_POR) || bus.lcd_en !== 1'b0 || bus.lcd_data !== 8'h00) begin
        n_err++;
        $display("FAIL por_wait k=%0d: ready=%0b en=%0b data=%02h want ready=%0b en=0 data=00",
                 k, bus.req_ready, bus.lcd_en, bus.lcd_data, (k == P_POR));
      end
    end
  endtask

  task automatic test_char_write();
    check_write(8'h41, 1'b1, OFF_SHORT, 1'b0);
  endtask

  // Long vs short execution wait classification.
  task automatic test_exec_wait();
    logic [7:0] cd [5] = '{8'h01, 8'h02, 8'h03, 8'h06, 8'h01};
    logic       cr [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         co [5] = '{OFF_LONG, OFF_LONG, OFF_LONG, OFF_SHORT, OFF_SHORT};
    for (int i = 0; i < 5; i++) check_write(cd[i], cr[i], co[i], 1'b0);
  endtask

  // Valid held across four writes. Accept-to-accept spacing is the busy
  // window plus the single IDLE cycle in which ready is visible.
  task automatic test_back_to_back();
    int r0;
    int gap_exp [3] = '{OFF_SHORT + 1, OFF_SHORT + 1, OFF_LONG + 1};
    acc_t.delete();
    r0 = en_rises;
    check_write(CMD_FUNC_8B2L,  1'b0, OFF_SHORT, 1'b1);
    check_write(CMD_DISPLAY_ON, 1'b0, OFF_SHORT, 1'b1);
    check_write(CMD_CLEAR,      1'b0, OFF_LONG,  1'b1);
    check_write(8'h48,          1'b1, OFF_SHORT, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (en_rises - r0 !== 4) begin
      n_err++; $display("FAIL b2b_pulses: got %0d want 4", en_rises - r0);
    end
    n_cmp++;
    if (acc_t.size() !== 4) begin
      n_err++; $display("FAIL b2b_accepts: got %0d want 4", acc_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if ((acc_t[i+1] - acc_t[i]) / 10 !== gap_exp[i]) begin
          n_err++;
          $display("FAIL b2b_gap%0d: got %0d want %0d", i, (acc_t[i+1] - acc_t[i]) / 10, gap_exp[i]);
        end
      end
    end
  endtask

  // Reset asserted while EN is high: pins drop without waiting for a clock.
  task automatic test_reset_in_pulse();
    int t;
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h53;
    bus.req_rs    = 1'b1;
    t = 0;
    while (!bus.lcd_en && t < 300) begin
      @(negedge clk);
      t++;
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (bus.lcd_en !== 1'b1) begin
      n_err++; $display("FAIL rip_reach_pulse: en=%0b want 1", bus.lcd_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.lcd_en !== 1'b0 || bus.lcd_rs !== 1'b0 || bus.lcd_data !== 8'h00 ||
        bus.lcd_rw !== 1'b0 || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rip_async_vals: en=%0b rs=%0b data=%02h rw=%0b ready=%0b busy=%0b want 0 0 00 0 0 1",
               bus.lcd_en, bus.lcd_rs, bus.lcd_data, bus.lcd_rw, bus.req_ready, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= P_POR; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== (k == P_POR) || bus.lcd_en !== 1'b0) begin
        n_err++;
        $display("FAIL rip_por k=%0d: ready=%0b en=%0b want ready=%0b en=0",
                 k, bus.req_ready, bus.lcd_en, (k == P_POR));
      end
    end
    check_write(CMD_ENTRY_INC, 1'b0, OFF_SHORT, 1'b0);
  endtask

  task automatic test_idle();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.lcd_en !== 1'b0 || bus.lcd_data !== last_data || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle k=%0d: en=%0b data=%02h busy=%0b want 0 %02h 0",
                 k, bus.lcd_en, bus.lcd_data, bus.busy, last_data);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.req_rs    = 1'b0;
    test_reset();
    test_char_write();
    test_exec_wait();
    test_back_to_back();
    test_reset_in_pulse();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
